bcd_updown_counter_n: RTL and testbench

Parametrised multi-digit BCD up/down counter with a per-digit modulus, for timer, clock and stopwatch displays. It generalises the single-digit down counter used in the lab timers in four ways: N cascaded digits in one block, selectable count direction, synchronous load, and a wrap-or-hold end mode. The count feeds the seven-segment display driver directly. A combinational end-of-range output lets instances cascade.

---
 rtl/bcd_updown_counter_n.sv | 136 +++++++++++++
 tb/tb_bcd_updown_counter_n.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter_n.sv
// bcd_updown_counter_n
//   Multi-digit BCD up/down counter with a per-digit modulus, meant to drive
//   seven-segment timer/clock/stopwatch displays directly. Each digit counts
//   0..L_d, where L_d is its nibble of `limit`. At the end of range the
//   counter either wraps or holds. `end_c` lets several instances cascade.
//
// Parameters
//   DIGITS     number of BCD digits (1..8). Digit 0 sits at bits [3:0].
//   RESET_VAL  value of `count` after reset.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   en           one count step per cycle while high
//   up           direction: 1 = increment, 0 = decrement
//   hold_at_end  1 = saturate at end of range, 0 = wrap
//   load         synchronous load of load_val (per-digit clamped to L_d)
//   load_val     value to load, one BCD digit per nibble
//   limit        per-digit maximum L_d
//   count        registered counter value
//   wrap         registered one-cycle pulse: the last step wrapped
//   end_c        combinational cascade carry/borrow: en AND at end of range
//   is_zero      combinational: every digit is 0
//   is_max       combinational: every digit is at (or above) its L_d
module bcd_updown_counter_n #(
  parameter int                  DIGITS    = 4,
  parameter logic [4*DIGITS-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  hold_at_end,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [4*DIGITS-1:0]   limit,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic                  end_c,
  output logic                  is_zero,
  output logic                  is_max
);

  localparam int W = 4 * DIGITS;

  // A limit nibble above 9 is not a BCD digit; treat it as 9.
  function automatic logic [3:0] sat_limit(input logic [3:0] l);
    return (l > 4'd9) ? 4'd9 : l;
  endfunction

  // Clamp a digit to its (already BCD-saturated) limit.
  function automatic logic [3:0] sat_digit(input logic [3:0] v, input logic [3:0] l);
    return (v > l) ? l : v;
  endfunction

  logic [W-1:0]    count_p1;
  logic            wrap_p1;
  logic [W-1:0]    lim_eff;
  logic [W-1:0]    load_sat;
  logic [W-1:0]    step_val;
  logic [DIGITS:0] chain;
  logic            zero_all;
  logic            max_all;
  logic            at_end;

  // Ripple carry/borrow across all digits in one cycle. Digit 0 always sees
  // the carry-in; a digit that rolls over passes it to the next one. The
  // natural ripple from all-zero (down) or all-max (up) already yields the
  // wrapped value, so no separate wrap path is needed.
  always_comb begin
    lim_eff  = '0;
    load_sat = '0;
    step_val = '0;
    chain    = '0;
    chain[0] = 1'b1;
    zero_all = 1'b1;
    max_all  = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      lim_eff[4*d +: 4]  = sat_limit(limit[4*d +: 4]);
      load_sat[4*d +: 4] = sat_digit(load_val[4*d +: 4], lim_eff[4*d +: 4]);
      if (count_p1[4*d +: 4] != 4'd0) zero_all = 1'b0;
      // >= so that a digit left above a reduced limit still counts as max
      if (count_p1[4*d +: 4] < lim_eff[4*d +: 4]) max_all = 1'b0;

      if (!chain[d]) begin
        step_val[4*d +: 4] = count_p1[4*d +: 4];
        chain[d+1]         = 1'b0;
      end else if (up) begin
        if (count_p1[4*d +: 4] >= lim_eff[4*d +: 4]) begin
          step_val[4*d +: 4] = 4'd0;
          chain[d+1]         = 1'b1;
        end else begin
          step_val[4*d +: 4] = count_p1[4*d +: 4] + 4'd1;
          chain[d+1]         = 1'b0;
        end
      end else begin
        if (count_p1[4*d +: 4] == 4'd0) begin
          step_val[4*d +: 4] = lim_eff[4*d +: 4];
          chain[d+1]         = 1'b1;
        end else begin
          // also covers a digit above its limit: it just decrements
          step_val[4*d +: 4] = count_p1[4*d +: 4] - 4'd1;
          chain[d+1]         = 1'b0;
        end
      end
    end
    at_end = up ? max_all : zero_all;
  end

  // ---- stage p1: count/wrap registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_p1 <= RESET_VAL;
      wrap_p1  <= 1'b0;
    end else if (load) begin
      count_p1 <= load_sat;
      wrap_p1  <= 1'b0;
    end else if (en) begin
      if (at_end && hold_at_end) begin
        wrap_p1 <= 1'b0;
      end else begin
        count_p1 <= step_val;
        wrap_p1  <= at_end;
      end
    end else begin
      wrap_p1 <= 1'b0;
    end
  end

  assign count   = count_p1;
  assign wrap    = wrap_p1;
  assign is_zero = zero_all;
  assign is_max  = max_all;
  assign end_c   = en & at_end;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// tb_bcd_updown_counter_n
//   Directed-vector bench for a 2-digit instance with RESET_VAL = 30.
//   Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_bcd_updown_counter_n;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       hold_at_end;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] limit;
  logic [7:0] count;
  logic       wrap;
  logic       end_c;
  logic       is_zero;
  logic       is_max;

  int total;
  int bad;

  bcd_updown_counter_n #(
    .DIGITS   (2),
    .RESET_VAL(8'h30)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .up         (up),
    .hold_at_end(hold_at_end),
    .load       (load),
    .load_val   (load_val),
    .limit      (limit),
    .count      (count),
    .wrap       (wrap),
    .end_c      (end_c),
    .is_zero    (is_zero),
    .is_max     (is_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; up = 1'b0; hold_at_end = 1'b0;
    load = 1'b0; load_val = 8'h00; limit = 8'h59;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    total++; if (count !== 8'h30) begin bad++; $display("FAIL reset_count got=%h want=%h", count, 8'h30); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b want=0", wrap); end
    total++; if (is_zero !== 1'b0) begin bad++; $display("FAIL reset_is_zero got=%b want=0", is_zero); end
    total++; if (is_max !== 1'b0) begin bad++; $display("FAIL reset_is_max got=%b want=0", is_max); end
    total++; if (end_c !== 1'b0) begin bad++; $display("FAIL reset_end_c got=%b want=0", end_c); end
  endtask

  task automatic test_down_wrap();
    load_val = 8'h01; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0; hold_at_end = 1'b0;
    #1;
    total++; if (count !== 8'h01) begin bad++; $display("FAIL dn_load got=%h want=%h", count, 8'h01); end
    total++; if (end_c !== 1'b0) begin bad++; $display("FAIL dn_end_c_01 got=%b want=0", end_c); end
    tick();
    total++; if (count !== 8'h00) begin bad++; $display("FAIL dn_00 got=%h want=%h", count, 8'h00); end
    total++; if (end_c !== 1'b1) begin bad++; $display("FAIL dn_end_c_00 got=%b want=1", end_c); end
    total++; if (is_zero !== 1'b1) begin bad++; $display("FAIL dn_is_zero got=%b want=1", is_zero); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL dn_wrap_00 got=%b want=0", wrap); end
    tick();
    total++; if (count !== 8'h59) begin bad++; $display("FAIL dn_wrap_59 got=%h want=%h", count, 8'h59); end
    total++; if (wrap !== 1'b1) begin bad++; $display("FAIL dn_wrap_pulse got=%b want=1", wrap); end
    total++; if (end_c !== 1'b0) begin bad++; $display("FAIL dn_end_c_59 got=%b want=0", end_c); end
    tick();
    total++; if (count !== 8'h58) begin bad++; $display("FAIL dn_58 got=%h want=%h", count, 8'h58); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL dn_wrap_once got=%b want=0", wrap); end
    en = 1'b0;
  endtask

  task automatic test_up_wrap();
    load_val = 8'h09; load = 1'b1; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    total++; if (count !== 8'h10) begin bad++; $display("FAIL up_09_10 got=%h want=%h", count, 8'h10); end
    en = 1'b0; load_val = 8'h58; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    total++; if (count !== 8'h59) begin bad++; $display("FAIL up_59 got=%h want=%h", count, 8'h59); end
    total++; if (is_max !== 1'b1) begin bad++; $display("FAIL up_is_max got=%b want=1", is_max); end
    total++; if (end_c !== 1'b1) begin bad++; $display("FAIL up_end_c got=%b want=1", end_c); end
    tick();
    total++; if (count !== 8'h00) begin bad++; $display("FAIL up_wrap_00 got=%h want=%h", count, 8'h00); end
    total++; if (wrap !== 1'b1) begin bad++; $display("FAIL up_wrap_pulse got=%b want=1", wrap); end
    tick();
    total++; if (count !== 8'h01) begin bad++; $display("FAIL up_01 got=%h want=%h", count, 8'h01); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL up_wrap_once got=%b want=0", wrap); end
    en = 1'b0;
  endtask

  task automatic test_hold();
    load_val = 8'h00; load = 1'b1;
    tick();
    load = 1'b0; hold_at_end = 1'b1; up = 1'b0; en = 1'b1;
    #1;
    total++; if (end_c !== 1'b1) begin bad++; $display("FAIL hold_end_c_pre got=%b want=1", end_c); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (count !== 8'h00) begin bad++; $display("FAIL hold_count[%0d] got=%h want=%h", i, count, 8'h00); end
      total++; if (wrap !== 1'b0) begin bad++; $display("FAIL hold_wrap[%0d] got=%b want=0", i, wrap); end
      total++; if (end_c !== 1'b1) begin bad++; $display("FAIL hold_end_c[%0d] got=%b want=1", i, end_c); end
    end
    en = 1'b0; hold_at_end = 1'b0;
  endtask

  task automatic test_load_clamp();
    load_val = 8'h7F; load = 1'b1;
    tick();
    total++; if (count !== 8'h59) begin bad++; $display("FAIL clamp_7F got=%h want=%h", count, 8'h59); end
    load_val = 8'h3A;
    tick();
    total++; if (count !== 8'h39) begin bad++; $display("FAIL clamp_3A got=%h want=%h", count, 8'h39); end
    load_val = 8'h12; en = 1'b1; up = 1'b1;
    tick();
    total++; if (count !== 8'h12) begin bad++; $display("FAIL load_prio got=%h want=%h", count, 8'h12); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL load_wrap got=%b want=0", wrap); end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_mid_reset();
    load_val = 8'h45; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    total++; if (count !== 8'h44) begin bad++; $display("FAIL mr_44 got=%h want=%h", count, 8'h44); end
    tick();
    rst_n = 1'b0;
    #1;
    total++; if (count !== 8'h43) begin bad++; $display("FAIL mr_sync got=%h want=%h", count, 8'h43); end
    tick();
    total++; if (count !== 8'h30) begin bad++; $display("FAIL mr_reset got=%h want=%h", count, 8'h30); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL mr_wrap got=%b want=0", wrap); end
    rst_n = 1'b1;
    tick();
    total++; if (count !== 8'h29) begin bad++; $display("FAIL mr_29 got=%h want=%h", count, 8'h29); end
    tick();
    total++; if (count !== 8'h28) begin bad++; $display("FAIL mr_28 got=%h want=%h", count, 8'h28); end
    en = 1'b0;
  endtask

  task automatic test_dir_flip();
    limit = 8'h09; load_val = 8'h07; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    total++; if (count !== 8'h08) begin bad++; $display("FAIL flip_08a got=%h want=%h", count, 8'h08); end
    up = 1'b0;
    tick();
    total++; if (count !== 8'h07) begin bad++; $display("FAIL flip_07 got=%h want=%h", count, 8'h07); end
    up = 1'b1;
    tick();
    total++; if (count !== 8'h08) begin bad++; $display("FAIL flip_08b got=%h want=%h", count, 8'h08); end
    tick();
    total++; if (count !== 8'h09) begin bad++; $display("FAIL zl_09 got=%h want=%h", count, 8'h09); end
    total++; if (is_max !== 1'b1) begin bad++; $display("FAIL zl_is_max got=%b want=1", is_max); end
    tick();
    total++; if (count !== 8'h00) begin bad++; $display("FAIL zl_wrap_00 got=%h want=%h", count, 8'h00); end
    total++; if (wrap !== 1'b1) begin bad++; $display("FAIL zl_wrap got=%b want=1", wrap); end
    up = 1'b0;
    tick();
    total++; if (count !== 8'h09) begin bad++; $display("FAIL zl_dn_09 got=%h want=%h", count, 8'h09); end
    en = 1'b0; limit = 8'h59;
  endtask

  task automatic test_back_to_back();
    load_val = 8'h18; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    total++; if (count !== 8'h19) begin bad++; $display("FAIL b2b_19 got=%h want=%h", count, 8'h19); end
    tick();
    total++; if (count !== 8'h20) begin bad++; $display("FAIL b2b_20 got=%h want=%h", count, 8'h20); end
    tick();
    total++; if (count !== 8'h21) begin bad++; $display("FAIL b2b_21 got=%h want=%h", count, 8'h21); end
    en = 1'b0;
    tick();
    total++; if (count !== 8'h21) begin bad++; $display("FAIL b2b_idle got=%h want=%h", count, 8'h21); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_down_wrap();
    test_up_wrap();
    test_hold();
    test_load_clamp();
    test_mid_reset();
    test_dir_flip();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
